// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and line idle level.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two; pop_data shows the head while !empty.
// Latency: a pushed word is visible at pop_data the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_data = mem_q[rd_q[AW-1:0]];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1, bit_end pulses on the last count, then wraps.
// Latency: bit_end is BIT_CYCLES-1 clocks after clear drops.
// Backpressure: none; clear holds the count at zero.
module uart_bit_timer #(
    parameter int BIT_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);
    localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a FIFO and sends them as 8N1 UART frames (8E1 with FIFO_UART_TX_PARITY_EN).
// Latency: tx falls one clock after the pop strobe; pop-to-pop 10*BIT_CYCLES+1 (11*.. with parity).
// Backpressure: pops only when idle and !empty, one byte per frame.
module fifo_uart_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int BIT_CYCLES = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] pop_data,
    output logic       pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    import uart_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        pop_q, pop_d;
    logic        busy_q, busy_d;
    logic        done_pend_q, done_pend_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic        timer_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    assign timer_clr = (state_q == ST_IDLE);

    uart_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clr),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        // The byte is captured while the pop strobe is on the pins.
        shift_d     = pop_q ? pop_data : shift_q;
        pop_d       = 1'b0;
        tx_d        = IDLE_LEVEL;
        busy_d      = (state_q != ST_IDLE);
        done_pend_d = 1'b0;
        done_d      = done_pend_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d       = pop_q ? ^pop_data : par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (!empty) begin
                    pop_d   = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = ~IDLE_LEVEL;
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = par_q;
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                tx_d = IDLE_LEVEL;
                if (bit_end) begin
                    state_d     = ST_IDLE;
                    done_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            tx_q        <= IDLE_LEVEL;
            pop_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            pop_q       <= pop_d;
            busy_q      <= busy_d;
            done_pend_q <= done_pend_d;
            done_q      <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign pop     = pop_q;
    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx fed by a real fifo; a pop-driven line model predicts tx/tx_busy/tx_done.
// Latency: n/a.  Backpressure: n/a.
module tb_fifo_uart_tx;
    import uart_pkg::*;

    localparam int BC = 10;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB = 1 + DATA_BITS + 1 + STOP_BITS;
`else
    localparam int FB = 1 + DATA_BITS + STOP_BITS;
`endif
    localparam int SPACING = FB * BC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       pop, empty, full, tx, tx_busy, tx_done;
    logic [7:0] pop_data;

    fifo #(.WIDTH(8), .DEPTH(16)) u_fifo (
        .clk       (clk),
        .rst       (fifo_rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty),
        .full      (full)
    );

    fifo_uart_tx #(.CLK_HZ(100), .BAUD(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .pop_data (pop_data),
        .pop      (pop),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: bytes accepted by the FIFO, and the waveform each pop implies.
    logic [7:0]    exp_q[$];
    int            pop_cyc[$];
    logic [FB-1:0] frame;
    logic [7:0]    cur_byte;
    int            fs = -1;
    int            done_at = -1;
    int            done_cnt = 0;
    int            done_last = 0;
    logic          prev_rst = 1'b1;
    logic          m_tx, m_busy;

    always @(negedge clk) begin
        cyc++;
        if (prev_rst) begin
            fs      = -1;
            done_at = -1;
            check("pop_in_reset", pop, 0);
        end
        m_tx   = 1'b1;
        m_busy = 1'b0;
        if (fs >= 0 && cyc > fs && cyc <= fs + FB * BC) begin
            m_busy = 1'b1;
            m_tx   = frame[(cyc - fs - 1) / BC];
        end
        check("tx", tx, m_tx);
        check("tx_busy", tx_busy, m_busy);
        check("tx_done", tx_done, (cyc == done_at));
        if (tx_done === 1'b1) begin
            done_cnt++;
            done_last = cyc;
        end
        if (pop === 1'b1 && !prev_rst) begin
            check("pop_while_empty", empty, 0);
            if (exp_q.size() == 0) begin
                check("pop_unexpected", pop, 0);
            end else begin
                cur_byte = exp_q.pop_front();
`ifdef FIFO_UART_TX_PARITY_EN
                frame = {1'b1, ^cur_byte, cur_byte, 1'b0};
`else
                frame = {1'b1, cur_byte, 1'b0};
`endif
                fs      = cyc;
                done_at = cyc + FB * BC + 1;
                pop_cyc.push_back(cyc);
            end
        end
        prev_rst = rst;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        if (!full) begin
            push      = 1'b1;
            push_data = b;
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        push = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int limit, input string tag);
        int k = 0;
        while (pop_cyc.size() < n && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, pop_cyc.size(), n);
    endtask

    initial begin
        int base;
        int k;

        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        fifo_rst = 1'b0;
        idle(200);
        check("reset_pops", pop_cyc.size(), 0);
        check("reset_empty", empty, 1);

        // Single byte
        push_byte(8'h55);
        wait_pops(1, 50, "single_pop");
        idle(SPACING + 20);
        check("single_pop_count", pop_cyc.size(), 1);
        check("single_done_count", done_cnt, 1);
        check("single_done_latency", done_last - pop_cyc[0], SPACING);
        check("single_empty_after", empty, 1);

        // Back-to-back
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'hA5);
        wait_pops(4, 3 * SPACING + 50, "b2b_pops");
        idle(SPACING + 50);
        check("b2b_no_fourth", pop_cyc.size(), 4);
        check("b2b_gap1", pop_cyc[2] - pop_cyc[1], SPACING);
        check("b2b_gap2", pop_cyc[3] - pop_cyc[2], SPACING);

        // Full FIFO drained
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'($urandom_range(0, 255)));
        end
        check("starve_full", full, 1);
        rst  = 1'b0;
        base = pop_cyc.size();
        wait_pops(base + 16, 16 * SPACING + 50, "starve_pops");
        idle(SPACING + 20);
        check("starve_pop_count", pop_cyc.size(), base + 16);
        check("starve_empty", empty, 1);
        for (int i = 1; i < 16; i++) begin
            check("starve_gap", pop_cyc[base + i] - pop_cyc[base + i - 1], SPACING);
        end

        // Reset during data bit 3 with a byte queued behind
        base = pop_cyc.size();
        push_byte(8'h3C);
        push_byte(8'h81);
        wait_pops(base + 1, 50, "midrst_first_pop");
        idle(4 * BC + 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", tx, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_done", tx_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_pops(base + 2, 50, "midrst_second_pop");
        idle(SPACING + 20);
        check("midrst_pop_count", pop_cyc.size(), base + 2);
        check("midrst_empty", empty, 1);

        // Parity-sensitive pair
        base = pop_cyc.size();
        push_byte(8'h07);
        push_byte(8'h03);
        wait_pops(base + 2, 2 * SPACING + 50, "par_pops");
        idle(SPACING + 20);
        check("par_gap", pop_cyc[base + 1] - pop_cyc[base], SPACING);

        // Random traffic with random gaps
        for (int i = 0; i < 20; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2 * SPACING));
        end
        k = 0;
        while ((exp_q.size() != 0) && k < 20 * SPACING) begin
            @(posedge clk);
            #1;
            k++;
        end
        idle(SPACING + 20);
        check("rand_drained", exp_q.size(), 0);
        check("rand_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
